// File: rtl/sw_pkg.sv
// Shared definitions for the stopwatch run controller: state encoding and
// default timing parameters for a 27 MHz system clock.
package sw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_LAP     = 2'b10,
    ST_STOPPED = 2'b11
  } sw_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 270_000;
  localparam int DEF_TICK_DIV        = 2_700_000;

endpackage

// File: rtl/sw_debounce.sv
// Synchroniser, debouncer and press-edge pulse for one active-low button.
// A button held through reset is ignored until it has been seen released.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level;
  logic          level_q;
  logic          armed;
  logic [1:0]    prime;
  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_a  <= 1'b1;
      sync_b  <= 1'b1;
      level   <= 1'b1;
      level_q <= 1'b1;
      armed   <= 1'b0;
      prime   <= 2'b00;
      cnt     <= '0;
    end else begin
      sync_a  <= btn_raw;
      sync_b  <= sync_a;
      prime   <= {prime[0], 1'b1};
      level_q <= level;
      if (sync_b != level) begin
        if (cnt == CMAX) begin
          level <= sync_b;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      // prime[1] marks the point where sync_b carries a real sample, not the reset value
      if (prime[1] && level && sync_b)
        armed <= 1'b1;
    end
  end

  assign press = armed & level_q & ~level;

endmodule

// File: rtl/sw_run_ctrl.sv
// Stopwatch run controller: debounced start/stop and lap/clear buttons drive
// a four-state FSM and a tick prescaler for the external time counter.
module sw_run_ctrl
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = DEF_TICK_DIV
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       btn_startstop,
  input  logic       btn_lap,
  output logic       run_en,
  output logic       tick,
  output logic       clr,
  output logic       freeze,
  output logic [1:0] state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic          ss_ev;
  logic          lap_ev;
  sw_state_t     cur_state;
  sw_state_t     nxt_state;
  logic [PW-1:0] pcnt;

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .btn_raw   (btn_startstop),
    .press     (ss_ev)
  );

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .btn_raw   (btn_lap),
    .press     (lap_ev)
  );

  // startstop always wins; a simultaneous lap event is simply dropped
  always_comb begin
    nxt_state = cur_state;
    clr       = 1'b0;
    case (cur_state)
      ST_IDLE: begin
        if (ss_ev) nxt_state = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (ss_ev)       nxt_state = ST_STOPPED;
        else if (lap_ev) nxt_state = ST_LAP;
      end
      ST_LAP: begin
        if (ss_ev)       nxt_state = ST_STOPPED;
        else if (lap_ev) nxt_state = ST_RUNNING;
      end
      ST_STOPPED: begin
        if (ss_ev) begin
          nxt_state = ST_RUNNING;
        end else if (lap_ev) begin
          nxt_state = ST_IDLE;
          clr       = 1'b1;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cur_state <= ST_IDLE;
      run_en    <= 1'b0;
      freeze    <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      run_en    <= (nxt_state == ST_RUNNING) || (nxt_state == ST_LAP);
      freeze    <= (nxt_state == ST_LAP);
    end
  end

  // Prescaler holds while stopped so a partial interval survives stop/start
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (run_en) begin
      pcnt <= (pcnt == PMAX) ? '0 : pcnt + 1'b1;
    end
  end

  assign tick  = run_en && (pcnt == PMAX) && !clr;
  assign state = cur_state;

endmodule

// File: tb/tb_sw_run_ctrl.sv
// Self-checking bench for sw_run_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=5.
module tb_sw_run_ctrl;

  localparam int TB_DEB  = 4;
  localparam int TB_TICK = 5;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       btn_startstop;
  logic       btn_lap;
  logic       run_en;
  logic       tick;
  logic       clr;
  logic       freeze;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_q[$];

  int   mcnt = 0;
  int   clr_cnt = 0;
  int   run_age = 0;
  int   first_tick_age = 0;
  logic run_en_q = 1'b0;
  logic saw_lap = 1'b0;
  logic exp_tick;

  sw_run_ctrl #(.DEBOUNCE_CYCLES(TB_DEB), .TICK_DIV(TB_TICK)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .btn_startstop (btn_startstop),
    .btn_lap       (btn_lap),
    .run_en        (run_en),
    .tick          (tick),
    .clr           (clr),
    .freeze        (freeze),
    .state         (state)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the end of the sequence");
    $fatal(1, "[TB] watchdog");
  end

  // Independent prescaler model: counts run_en-high cycles, cleared by clr or reset
  always @(negedge sys_clk) begin
    exp_tick = run_en && (mcnt == TB_TICK - 1) && !clr;
    total++;
    if (tick !== exp_tick) begin
      bad++;
      $display("[TB] FAIL tick_cadence t=%0t tick=%b expected=%b", $time, tick, exp_tick);
    end
    if (clr === 1'b1) clr_cnt++;
    if (state === 2'b10) saw_lap = 1'b1;
    if (run_en && !run_en_q) begin
      run_age = 1;
      first_tick_age = 0;
    end else if (run_en) begin
      run_age++;
    end
    if (tick && first_tick_age == 0) first_tick_age = run_age;
    run_en_q = run_en;
    if (!sys_rst_n || clr) mcnt = 0;
    else if (run_en) mcnt = (mcnt == TB_TICK - 1) ? 0 : mcnt + 1;
  end

  task automatic press(input logic ss, input logic lp, input logic [1:0] exp_state);
    logic [1:0] prev;
    logic [1:0] want;
    int n;
    exp_q.push_back(exp_state);
    prev = state;
    @(negedge sys_clk);
    if (ss) btn_startstop = 1'b0;
    if (lp) btn_lap = 1'b0;
    n = 0;
    while (state === prev && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    want = exp_q.pop_front();
    total++;
    if (state !== want)
      begin bad++; $display("[TB] FAIL press_state state=%b expected=%b waited=%0d", state, want, n); end
    repeat (10) @(negedge sys_clk);
    btn_startstop = 1'b1;
    btn_lap = 1'b1;
    repeat (15) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    btn_startstop = 1'b1;
    btn_lap = 1'b1;
    repeat (3) @(negedge sys_clk);
    total++;
    if ({state, run_en, tick, clr, freeze} !== 6'b0)
      begin bad++; $display("[TB] FAIL reset_outputs got=%b expected=000000", {state, run_en, tick, clr, freeze}); end
    #2 sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_glitch();
    @(negedge sys_clk);
    btn_startstop = 1'b0;
    repeat (3) @(negedge sys_clk);
    btn_startstop = 1'b1;
    repeat (20) @(negedge sys_clk);
    total++;
    if (state !== 2'b00 || run_en !== 1'b0)
      begin bad++; $display("[TB] FAIL glitch_ignored state=%b run_en=%b expected 00/0", state, run_en); end
  endtask

  task automatic test_start();
    int n;
    int t0;
    press(1'b1, 1'b0, 2'b01);
    total++;
    if (run_en !== 1'b1 || freeze !== 1'b0)
      begin bad++; $display("[TB] FAIL start_outputs run_en=%b freeze=%b expected 1/0", run_en, freeze); end
    total++;
    if (first_tick_age !== TB_TICK)
      begin bad++; $display("[TB] FAIL start_first_tick age=%0d expected=%0d", first_tick_age, TB_TICK); end
    n = 0;
    while (tick !== 1'b1 && n < 20) begin @(negedge sys_clk); n++; end
    t0 = 0;
    @(negedge sys_clk);
    t0 = 1;
    while (tick !== 1'b1 && t0 < 20) begin @(negedge sys_clk); t0++; end
    total++;
    if (t0 !== TB_TICK)
      begin bad++; $display("[TB] FAIL tick_period got=%0d expected=%0d", t0, TB_TICK); end
  endtask

  task automatic test_lap();
    press(1'b0, 1'b1, 2'b10);
    total++;
    if (freeze !== 1'b1 || run_en !== 1'b1)
      begin bad++; $display("[TB] FAIL lap_outputs freeze=%b run_en=%b expected 1/1", freeze, run_en); end
    press(1'b0, 1'b1, 2'b01);
    total++;
    if (freeze !== 1'b0 || run_en !== 1'b1)
      begin bad++; $display("[TB] FAIL lap_release freeze=%b run_en=%b expected 0/1", freeze, run_en); end
  endtask

  task automatic test_stop_restart();
    int n;
    int held;
    int clr_before;
    n = 0;
    while (tick !== 1'b1 && n < 20) begin @(negedge sys_clk); n++; end
    press(1'b1, 1'b0, 2'b11);
    held = mcnt;
    total++;
    if (run_en !== 1'b0 || freeze !== 1'b0)
      begin bad++; $display("[TB] FAIL stop_outputs run_en=%b freeze=%b expected 0/0", run_en, freeze); end
    repeat (50) @(negedge sys_clk);
    press(1'b1, 1'b0, 2'b01);
    total++;
    if (first_tick_age !== TB_TICK - held)
      begin bad++; $display("[TB] FAIL resume_first_tick age=%0d expected=%0d", first_tick_age, TB_TICK - held); end
    press(1'b1, 1'b0, 2'b11);
    clr_before = clr_cnt;
    press(1'b0, 1'b1, 2'b00);
    total++;
    if (clr_cnt - clr_before !== 1)
      begin bad++; $display("[TB] FAIL clear_pulse cycles=%0d expected=1", clr_cnt - clr_before); end
    total++;
    if (run_en !== 1'b0 || freeze !== 1'b0)
      begin bad++; $display("[TB] FAIL clear_outputs run_en=%b freeze=%b expected 0/0", run_en, freeze); end
    press(1'b0, 1'b1, 2'b00);
    total++;
    if (clr_cnt - clr_before !== 1)
      begin bad++; $display("[TB] FAIL idle_lap_ignored clr_cycles=%0d expected=1", clr_cnt - clr_before); end
    press(1'b1, 1'b0, 2'b01);
    total++;
    if (first_tick_age !== TB_TICK)
      begin bad++; $display("[TB] FAIL fresh_first_tick age=%0d expected=%0d", first_tick_age, TB_TICK); end
  endtask

  task automatic test_simultaneous();
    saw_lap = 1'b0;
    press(1'b1, 1'b1, 2'b11);
    total++;
    if (saw_lap !== 1'b0 || freeze !== 1'b0)
      begin bad++; $display("[TB] FAIL both_buttons saw_lap=%b freeze=%b expected 0/0", saw_lap, freeze); end
    press(1'b1, 1'b0, 2'b01);
  endtask

  task automatic test_reset_held();
    int clr_before;
    clr_before = clr_cnt;
    @(negedge sys_clk);
    btn_startstop = 1'b0;
    repeat (3) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    total++;
    if ({state, run_en, tick, clr, freeze} !== 6'b0)
      begin bad++; $display("[TB] FAIL reset_mid_run got=%b expected=000000", {state, run_en, tick, clr, freeze}); end
    repeat (3) @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    repeat (30) @(negedge sys_clk);
    total++;
    if (state !== 2'b00 || clr_cnt !== clr_before)
      begin bad++; $display("[TB] FAIL held_after_reset state=%b clr_cycles=%0d expected 00/0", state, clr_cnt - clr_before); end
    btn_startstop = 1'b1;
    repeat (20) @(negedge sys_clk);
    total++;
    if (state !== 2'b00)
      begin bad++; $display("[TB] FAIL release_after_reset state=%b expected=00", state); end
    press(1'b1, 1'b0, 2'b01);
    total++;
    if (run_en !== 1'b1)
      begin bad++; $display("[TB] FAIL repress_after_reset run_en=%b expected=1", run_en); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_start();
    test_lap();
    test_stop_restart();
    test_simultaneous();
    test_reset_held();
    repeat (10) @(negedge sys_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
